// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a word-addressed ROM and presents one instruction
// per cycle over a valid/ready handshake, with redirect flush and ebreak halt.
module fetch_unit #(
  parameter int WIDTH  = 32,
  parameter int INS_AS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [INS_AS-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [WIDTH-1:0]  ins_data,
  output logic [INS_AS-1:0] ins_pc,
  input  logic              redirect_valid,
  input  logic [INS_AS-1:0] redirect_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [WIDTH-1:0] EBREAK = WIDTH'(32'h0010_0073);

  state_t            state, state_next;
  logic [INS_AS-1:0] pc;
  logic              load;
  logic              handshake;
  logic              is_ebreak;

  // A redirect always wins over a load in the same cycle, so the flushed slot is never refilled early.
  assign load      = (state == RUN) && !redirect_valid && (!ins_valid || ins_ready);
  assign handshake = ins_valid && ins_ready;
  assign is_ebreak = (rom_data == EBREAK);
  assign rom_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && start) state_next = RUN;
      end
      RUN: begin
        if (load && is_ebreak) state_next = HALT;
      end
      HALT: begin
        if (redirect_valid || start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    halted = (state == HALT);
  end

  // In IDLE the output slot is already empty, so clearing ins_valid on redirect only matters in RUN/HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      ins_valid   <= 1'b0;
      ins_data    <= '0;
      ins_pc      <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      ins_valid <= 1'b0;
    end else if (load) begin
      ins_data    <= rom_data;
      ins_pc      <= pc;
      ins_valid   <= 1'b1;
      pc          <= pc + 1'b1;
      fetch_count <= fetch_count + 16'd1;
    end else if (handshake) begin
      ins_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 16-word ROM model drives rom_data from rom_addr,
// and every step checks outputs against hand-computed values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [3:0]  ins_pc;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [16];
  int checks = 0;
  int errors = 0;

  fetch_unit #(.WIDTH(32), .INS_AS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic valid, input logic [3:0] pc,
                             input logic [31:0] data, input logic [15:0] count,
                             input logic [3:0] addr, input logic halt);
    check_output({tag, ".valid"}, 32'(ins_valid), 32'(valid));
    if (valid) begin
      check_output({tag, ".pc"}, 32'(ins_pc), 32'(pc));
      check_output({tag, ".data"}, ins_data, data);
    end
    check_output({tag, ".count"}, 32'(fetch_count), 32'(count));
    check_output({tag, ".addr"}, 32'(rom_addr), 32'(addr));
    check_output({tag, ".halted"}, 32'(halted), 32'(halt));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = 32'hA000_0000 + 32'(k);
    rst = 1'b1; start = 1'b0; ins_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 4'd0;

    step();
    apply_reset();
    check_output("reset.valid", 32'(ins_valid), 32'd0);
    check_output("reset.data", ins_data, 32'd0);
    check_output("reset.pc", 32'(ins_pc), 32'd0);
    check_output("reset.count", 32'(fetch_count), 32'd0);
    check_output("reset.halted", 32'(halted), 32'd0);
    check_output("reset.addr", 32'(rom_addr), 32'd0);

    // Redirect while idle only moves pc; start then fetches from the new target.
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    step();
    redirect_valid = 1'b0;
    check_state("idle_redir", 1'b0, 4'd0, 32'd0, 16'd0, 4'd9, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("idle_start", 1'b0, 4'd0, 32'd0, 16'd0, 4'd9, 1'b0);
    step();
    check_state("idle_first", 1'b1, 4'd9, 32'hA000_0009, 16'd1, 4'd10, 1'b0);

    // Streaming with ins_ready high, including the 15 -> 0 wrap.
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("stream_start", 1'b0, 4'd0, 32'd0, 16'd0, 4'd0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      step();
      check_state($sformatf("stream%0d", i), 1'b1, 4'(i % 16),
                  32'hA000_0000 + 32'(i % 16), 16'(i + 1), 4'((i + 1) % 16), 1'b0);
    end

    // Stall three cycles on instruction 5, then release.
    for (int i = 1; i <= 5; i++) step();
    check_state("pre_stall", 1'b1, 4'd5, 32'hA000_0005, 16'd22, 4'd6, 1'b0);
    ins_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("stall%0d", i), 1'b1, 4'd5, 32'hA000_0005, 16'd22, 4'd6, 1'b0);
    end
    ins_ready = 1'b1;
    step();
    check_state("release", 1'b1, 4'd6, 32'hA000_0006, 16'd23, 4'd7, 1'b0);

    // Redirect to 12 while instruction 3 is presented flushes it even with ins_ready high.
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_state("pre_redir", 1'b1, 4'd3, 32'hA000_0003, 16'd4, 4'd4, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 4'd12;
    step();
    redirect_valid = 1'b0;
    check_state("redir_flush", 1'b0, 4'd0, 32'd0, 16'd4, 4'd12, 1'b0);
    step();
    check_state("redir_target", 1'b1, 4'd12, 32'hA000_000C, 16'd5, 4'd13, 1'b0);

    // ebreak at word 7 halts after presenting it; start resumes at 8.
    rom[7] = 32'h0010_0073;
    apply_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check_state("pre_halt", 1'b1, 4'd6, 32'hA000_0006, 16'd7, 4'd7, 1'b0);
    step();
    check_state("halt_present", 1'b1, 4'd7, 32'h0010_0073, 16'd8, 4'd8, 1'b1);
    step();
    check_state("halt_drain", 1'b0, 4'd0, 32'd0, 16'd8, 4'd8, 1'b1);
    step();
    check_state("halt_hold", 1'b0, 4'd0, 32'd0, 16'd8, 4'd8, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_state("halt_start", 1'b0, 4'd0, 32'd0, 16'd8, 4'd8, 1'b0);
    step();
    check_state("halt_resume", 1'b1, 4'd8, 32'hA000_0008, 16'd9, 4'd9, 1'b0);

    // Reset beats a pending instruction, a redirect and start in the same cycle.
    ins_ready = 1'b0;
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd5; start = 1'b1;
    step();
    rst = 1'b0; redirect_valid = 1'b0; start = 1'b0;
    check_state("rst_mid", 1'b0, 4'd0, 32'd0, 16'd0, 4'd0, 1'b0);
    check_output("rst_mid.data", ins_data, 32'd0);
    check_output("rst_mid.pc", 32'(ins_pc), 32'd0);
    ins_ready = 1'b1;
    step();
    check_state("rst_idle", 1'b0, 4'd0, 32'd0, 16'd0, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
